// File: rtl/membus_arbiter.sv
// Two-requester Membus arbiter (instruction fetch vs data) with one outstanding
// transaction and a response watchdog. Define MEMBUS_ARB_RR_EN for round-robin arbitration.
module membus_arbiter #(
    parameter int XLEN         = 32,
    parameter int RESP_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    // instruction-fetch requester
    input  logic              i_membus_valid,
    output logic              i_membus_ready,
    input  logic [XLEN-1:0]   i_membus_addr,
    input  logic              i_membus_wen,
    input  logic [XLEN-1:0]   i_membus_wdata,
    input  logic [XLEN/8-1:0] i_membus_wmask,
    output logic              i_membus_rvalid,
    output logic [XLEN-1:0]   i_membus_rdata,
    // data requester
    input  logic              d_membus_valid,
    output logic              d_membus_ready,
    input  logic [XLEN-1:0]   d_membus_addr,
    input  logic              d_membus_wen,
    input  logic [XLEN-1:0]   d_membus_wdata,
    input  logic [XLEN/8-1:0] d_membus_wmask,
    output logic              d_membus_rvalid,
    output logic [XLEN-1:0]   d_membus_rdata,
    // shared downstream slave
    output logic              membus_valid,
    input  logic              membus_ready,
    output logic [XLEN-1:0]   membus_addr,
    output logic              membus_wen,
    output logic [XLEN-1:0]   membus_wdata,
    output logic [XLEN/8-1:0] membus_wmask,
    input  logic              membus_rvalid,
    input  logic [XLEN-1:0]   membus_rdata,
    // status
    output logic              busy,
    output logic              owner,
    output logic              timeout_err
);

    localparam int CW = (RESP_TIMEOUT > 0) ? $clog2(RESP_TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_VAL = CW'(RESP_TIMEOUT);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          sel_d;
    logic          accept;
    logic          fire;
    logic          resp;

`ifdef MEMBUS_ARB_RR_EN
    // last_grant: 0 = i, 1 = d; under contention the other requester wins
    logic last_grant;

    assign sel_d = d_membus_valid && (!i_membus_valid || !last_grant);

    always_ff @(posedge clk) begin
        if (rst)
            last_grant <= 1'b0;
        else if (accept)
            last_grant <= sel_d;
    end
`else
    assign sel_d = d_membus_valid;
`endif

    assign accept = (state == IDLE) && (i_membus_valid || d_membus_valid) && membus_ready;
    // wait_cnt + 1 counts the current WAIT cycle, so the watchdog fires RESP_TIMEOUT cycles after acceptance
    assign fire   = (RESP_TIMEOUT != 0) && (state == WAIT) && !membus_rvalid
                    && ((wait_cnt + CW'(1)) == TIMEOUT_VAL);
    assign resp   = (state == WAIT) && (membus_rvalid || fire);
    assign busy   = (state == WAIT);

    assign membus_addr  = sel_d ? d_membus_addr  : i_membus_addr;
    assign membus_wen   = sel_d ? d_membus_wen   : i_membus_wen;
    assign membus_wdata = sel_d ? d_membus_wdata : i_membus_wdata;
    assign membus_wmask = sel_d ? d_membus_wmask : i_membus_wmask;

    always_comb begin
        state_next      = state;
        membus_valid    = 1'b0;
        i_membus_ready  = 1'b0;
        d_membus_ready  = 1'b0;
        i_membus_rvalid = 1'b0;
        d_membus_rvalid = 1'b0;
        i_membus_rdata  = '0;
        d_membus_rdata  = '0;
        case (state)
            IDLE: begin
                membus_valid   = i_membus_valid || d_membus_valid;
                d_membus_ready = sel_d && membus_ready;
                i_membus_ready = i_membus_valid && !sel_d && membus_ready;
                if (accept)
                    state_next = WAIT;
            end
            WAIT: begin
                if (resp) begin
                    if (owner) begin
                        d_membus_rvalid = 1'b1;
                        d_membus_rdata  = membus_rvalid ? membus_rdata : '0;
                    end else begin
                        i_membus_rvalid = 1'b1;
                        i_membus_rdata  = membus_rvalid ? membus_rdata : '0;
                    end
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            wait_cnt    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                owner    <= sel_d;
                wait_cnt <= '0;
            end else if ((state == WAIT) && !membus_rvalid) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
            if (fire)
                timeout_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_membus_arbiter.sv
// Directed self-checking bench for membus_arbiter (RESP_TIMEOUT = 8);
// contention expectations follow MEMBUS_ARB_RR_EN when it is defined.
module tb_membus_arbiter;

    localparam int XLEN = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              iValid, iReady, iWen, iRvalid;
    logic [XLEN-1:0]   iAddr, iWdata, iRdata;
    logic [XLEN/8-1:0] iWmask;
    logic              dValid, dReady, dWen, dRvalid;
    logic [XLEN-1:0]   dAddr, dWdata, dRdata;
    logic [XLEN/8-1:0] dWmask;
    logic              mValid, mReady, mWen, mRvalid;
    logic [XLEN-1:0]   mAddr, mWdata, mRdata;
    logic [XLEN/8-1:0] mWmask;
    logic              busy, owner, timeoutErr;

    int checkCount = 0;
    int passCount  = 0;

    membus_arbiter #(.XLEN(XLEN), .RESP_TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_membus_valid(iValid), .i_membus_ready(iReady), .i_membus_addr(iAddr),
        .i_membus_wen(iWen), .i_membus_wdata(iWdata), .i_membus_wmask(iWmask),
        .i_membus_rvalid(iRvalid), .i_membus_rdata(iRdata),
        .d_membus_valid(dValid), .d_membus_ready(dReady), .d_membus_addr(dAddr),
        .d_membus_wen(dWen), .d_membus_wdata(dWdata), .d_membus_wmask(dWmask),
        .d_membus_rvalid(dRvalid), .d_membus_rdata(dRdata),
        .membus_valid(mValid), .membus_ready(mReady), .membus_addr(mAddr),
        .membus_wen(mWen), .membus_wdata(mWdata), .membus_wmask(mWmask),
        .membus_rvalid(mRvalid), .membus_rdata(mRdata),
        .busy(busy), .owner(owner), .timeout_err(timeoutErr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        iv, dv, mready;
        logic        expMvalid, expIready, expDready;
        logic [31:0] expAddr;
        logic        expWen;
    } vec_t;

    vec_t vecs[6];
    logic expD[8];

    task automatic applyStimulus(input logic iv, input logic dv, input logic mready,
                                 input logic mrvalid, input logic [XLEN-1:0] mrdata);
        iValid  = iv;
        dValid  = dv;
        mReady  = mready;
        mRvalid = mrvalid;
        mRdata  = mrdata;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp)
            passCount++;
        else
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset;
        rst = 1'b1;
        applyStimulus(0, 0, 0, 0, '0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        iAddr = 32'h100; iWen = 1'b0; iWdata = 32'h1111; iWmask = 4'hF;
        dAddr = 32'h200; dWen = 1'b1; dWdata = 32'h2222; dWmask = 4'h3;
        applyStimulus(0, 0, 0, 0, '0);
        vecs[0] = '{0, 0, 1, 0, 0, 0, 32'h0,   1'b0};
        vecs[1] = '{1, 0, 1, 1, 1, 0, 32'h100, 1'b0};
        vecs[2] = '{1, 0, 0, 1, 0, 0, 32'h100, 1'b0};
        vecs[3] = '{0, 1, 1, 1, 0, 1, 32'h200, 1'b1};
        vecs[4] = '{1, 1, 1, 1, 0, 1, 32'h200, 1'b1};
        vecs[5] = '{1, 1, 0, 1, 0, 0, 32'h200, 1'b1};
`ifdef MEMBUS_ARB_RR_EN
        expD = '{1, 0, 1, 0, 1, 0, 1, 0};
`else
        expD = '{1, 1, 1, 1, 0, 0, 0, 0};
`endif
        tick(); tick();
        rst = 1'b0;

        // reset state
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy}, 0);
        checkOutput("rst_owner", {31'b0, owner}, 0);
        checkOutput("rst_terr", {31'b0, timeoutErr}, 0);
        checkOutput("rst_mvalid", {31'b0, mValid}, 0);
        checkOutput("rst_rvalid", {30'b0, iRvalid, dRvalid}, 0);
        tick();

        // IDLE arbitration/mux vectors; valids dropped before the edge so nothing is accepted
        for (int k = 0; k < 6; k++) begin
            applyStimulus(vecs[k].iv, vecs[k].dv, vecs[k].mready, 0, '0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_mvalid", k), {31'b0, mValid}, {31'b0, vecs[k].expMvalid});
            checkOutput($sformatf("vec%0d_iready", k), {31'b0, iReady}, {31'b0, vecs[k].expIready});
            checkOutput($sformatf("vec%0d_dready", k), {31'b0, dReady}, {31'b0, vecs[k].expDready});
            if (vecs[k].expMvalid) begin
                checkOutput($sformatf("vec%0d_addr", k), mAddr, vecs[k].expAddr);
                checkOutput($sformatf("vec%0d_wen", k), {31'b0, mWen}, {31'b0, vecs[k].expWen});
            end
            #1;
            applyStimulus(0, 0, 0, 0, '0);
            tick();
            checkOutput($sformatf("vec%0d_busy", k), {31'b0, busy}, 0);
        end

        // i read, 1-cycle slave
        doReset();
        applyStimulus(1, 0, 1, 0, '0);
        @(negedge clk);
        checkOutput("rd_iready", {31'b0, iReady}, 1);
        tick();
        applyStimulus(0, 0, 0, 1, 32'hDEADBEEF);
        @(negedge clk);
        checkOutput("rd_busy", {31'b0, busy}, 1);
        checkOutput("rd_irvalid", {31'b0, iRvalid}, 1);
        checkOutput("rd_irdata", iRdata, 32'hDEADBEEF);
        checkOutput("rd_drvalid", {31'b0, dRvalid}, 0);
        tick();
        applyStimulus(0, 0, 0, 0, '0);
        @(negedge clk);
        checkOutput("rd_busy_after", {31'b0, busy}, 0);
        checkOutput("rd_irvalid_after", {31'b0, iRvalid}, 0);
        tick();

        // continuous contention: 4 requests from each side
        doReset();
        begin
            int iLeft = 4;
            int dLeft = 4;
            for (int n = 0; n < 8; n++) begin
                applyStimulus(iLeft > 0, dLeft > 0, 1, 0, '0);
                @(negedge clk);
                checkOutput($sformatf("grant%0d_d", n), {31'b0, dReady}, {31'b0, expD[n]});
                checkOutput($sformatf("grant%0d_i", n), {31'b0, iReady}, {31'b0, !expD[n]});
                tick();
                if (expD[n]) dLeft--; else iLeft--;
                applyStimulus(iLeft > 0, dLeft > 0, 1, 1, 32'h1000 + n);
                @(negedge clk);
                checkOutput($sformatf("grant%0d_owner", n), {31'b0, owner}, {31'b0, expD[n]});
                checkOutput($sformatf("grant%0d_noacc", n), {30'b0, iReady, dReady}, 0);
                checkOutput($sformatf("grant%0d_rv", n), {30'b0, dRvalid, iRvalid},
                            expD[n] ? 32'd2 : 32'd1);
                tick();
            end
            applyStimulus(0, 0, 0, 0, '0);
        end

        // d write with slave stalling ready for 3 cycles
        doReset();
        dAddr = 32'h300; dWdata = 32'hCAFEF00D; dWmask = 4'b0011; dWen = 1'b1;
        for (int c = 0; c < 3; c++) begin
            applyStimulus(0, 1, 0, 0, '0);
            @(negedge clk);
            checkOutput($sformatf("stall%0d_dready", c), {31'b0, dReady}, 0);
            checkOutput($sformatf("stall%0d_payload", c), mAddr ^ mWdata, 32'h300 ^ 32'hCAFEF00D);
            checkOutput($sformatf("stall%0d_ctl", c), {26'b0, mValid, mWen, mWmask}, 32'h33);
            tick();
        end
        applyStimulus(0, 1, 1, 0, '0);
        @(negedge clk);
        checkOutput("wr_dready", {31'b0, dReady}, 1);
        checkOutput("wr_mwmask", {28'b0, mWmask}, 32'h3);
        tick();
        applyStimulus(0, 0, 1, 0, '0);
        @(negedge clk);
        checkOutput("wr_nodup", {31'b0, mValid}, 0);
        checkOutput("wr_busy", {31'b0, busy}, 1);
        tick();
        applyStimulus(0, 0, 0, 1, '0);
        @(negedge clk);
        checkOutput("wr_drvalid", {31'b0, dRvalid}, 1);
        tick();
        applyStimulus(0, 0, 0, 0, '0);
        @(negedge clk);
        checkOutput("wr_drvalid_once", {31'b0, dRvalid}, 0);
        tick();

        // watchdog: slave never responds, then responds exactly at T+8
        for (int pass = 0; pass < 2; pass++) begin
            doReset();
            applyStimulus(1, 0, 1, 0, '0);
            @(negedge clk);
            checkOutput($sformatf("wd%0d_accept", pass), {31'b0, iReady}, 1);
            tick();
            applyStimulus(0, 0, 0, 0, '0);
            for (int j = 1; j < 8; j++) begin
                @(negedge clk);
                checkOutput($sformatf("wd%0d_wait%0d", pass, j), {30'b0, busy, iRvalid}, 32'd2);
                tick();
            end
            if (pass == 1) applyStimulus(0, 0, 0, 1, 32'h55);
            @(negedge clk);
            checkOutput($sformatf("wd%0d_rvalid", pass), {31'b0, iRvalid}, 1);
            checkOutput($sformatf("wd%0d_rdata", pass), iRdata, (pass == 1) ? 32'h55 : 32'h0);
            checkOutput($sformatf("wd%0d_terr_early", pass), {31'b0, timeoutErr}, 0);
            tick();
            applyStimulus(0, 0, 0, 0, '0);
            @(negedge clk);
            checkOutput($sformatf("wd%0d_terr", pass), {31'b0, timeoutErr}, (pass == 1) ? 32'd0 : 32'd1);
            checkOutput($sformatf("wd%0d_idle", pass), {31'b0, busy}, 0);
            tick(); tick(); tick();
            @(negedge clk);
            checkOutput($sformatf("wd%0d_terr_sticky", pass), {31'b0, timeoutErr}, (pass == 1) ? 32'd0 : 32'd1);
            tick();
        end
        doReset();
        @(negedge clk);
        checkOutput("wd_terr_cleared", {31'b0, timeoutErr}, 0);
        tick();

        // reset in WAIT; late response must be dropped
        applyStimulus(0, 1, 1, 0, '0);
        @(negedge clk);
        checkOutput("rw_accept", {31'b0, dReady}, 1);
        tick();
        applyStimulus(0, 0, 0, 0, '0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rw_owner_pre", {31'b0, owner}, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rw_busy_post", {31'b0, busy}, 0);
        tick();
        applyStimulus(0, 0, 0, 1, 32'h77);
        @(negedge clk);
        checkOutput("rw_late_rvalid", {30'b0, iRvalid, dRvalid}, 0);
        checkOutput("rw_outputs", {27'b0, busy, owner, timeoutErr, mValid, iReady | dReady}, 0);
        tick();
        applyStimulus(0, 0, 0, 0, '0);
        @(negedge clk);
        checkOutput("rw_still_idle", {31'b0, busy}, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/membus_arbiter.md
# membus_arbiter

Two-requester arbiter that shares one downstream Membus slave (RAM, aclint_memory, or an MMIO decoder) between the core's instruction-fetch port and data port. It keeps one transaction outstanding at a time, records which requester owns it, and routes the response back only to that owner. A response watchdog stops a dead slave from hanging the core.

## Interface
Parameters:
- RESP_TIMEOUT, default 255: cycles to wait for downstream rvalid after acceptance before a synthetic response is returned; 0 disables the watchdog.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- i_membus  Membus.slave  Membus (XLEN addr/data, XLEN/8 wmask)  instruction-fetch requester.
- d_membus  Membus.slave  Membus  data (load/store) requester.
- membus  Membus.master  Membus  shared downstream slave.
- busy  output  1  high while a transaction is outstanding (state WAIT).
- owner  output  1  owner of the current or last transaction: 0 = i, 1 = d.
- timeout_err  output  1  sticky; set when the watchdog fires.

## Operation
- FSM states: IDLE, WAIT.
- IDLE: winner = requester with valid high, chosen by the priority rule (see Configuration). Mux the winner's addr/wen/wdata/wmask onto membus. membus.valid = winner valid. Winner ready = membus.ready; loser ready = 0.
- Acceptance (winner valid && membus.ready in IDLE): latch owner, clear timeout counter, go to WAIT.
- WAIT: membus.valid = 0; i_membus.ready = d_membus.ready = 0.
- On membus.rvalid in WAIT: drive owner.rvalid = 1 and owner.rdata = membus.rdata in the same cycle (combinational); the non-owner's rvalid = 0. Next state is IDLE.
- Every accepted request, read or write, gets exactly one rvalid.
- Requesters hold valid and payload stable until ready. Dropping valid before ready is legal and simply loses arbitration.
- A membus.rvalid in IDLE (spurious, or in flight across a reset) is ignored: no rvalid to either requester and no state change.
- Watchdog, when RESP_TIMEOUT != 0: the counter increments each WAIT cycle without rvalid. When it equals RESP_TIMEOUT, drive owner.rvalid = 1 with rdata = 0, set timeout_err, and go to IDLE. A real rvalid in that same cycle takes precedence: its rdata is returned and timeout_err is not set. Counter width is $clog2(RESP_TIMEOUT+1).
- Reset values: state IDLE, owner 0, counter 0, timeout_err 0, busy 0.
- Reset has priority over everything, including mid-WAIT: the outstanding transaction is abandoned and its late response is dropped.
- All rvalid and ready outputs are combinational from state, so they are 0 while in IDLE or WAIT after reset until a request arrives.

## Timing
- IDLE acceptance adds zero cycles: the request reaches membus in the cycle it is presented.
- Response is passed back in the same cycle as membus.rvalid.
- With request accepted at T and downstream rvalid at T+k (k ≥ 1), the requester sees rvalid at T+k. The next acceptance is T+k+1 at the earliest.
- Nothing is accepted in the rvalid cycle.
- Back-to-back throughput with a 1-cycle slave: one transaction per 2 cycles.
- Watchdog fires at T+RESP_TIMEOUT. timeout_err is visible from T+RESP_TIMEOUT+1.

## Configuration
- MEMBUS_ARB_RR_EN undefined: fixed priority. d wins whenever d_membus.valid is high; i can be starved by continuous d traffic.
- MEMBUS_ARB_RR_EN defined: round-robin.
  - A last-grant bit updates on each acceptance. When both requesters are valid, the one not granted last wins; a single valid requester always wins.
  - last-grant resets to i, so d wins the first contention.

## Test plan
- i_membus read of addr 0x100 with a 1-cycle slave returning 0xDEADBEEF -> i rvalid at T+1 with that data; d rvalid stays 0; busy high for exactly 1 cycle.
- i and d both valid in IDLE, fixed priority -> d accepted first and i on the following IDLE cycle. With MEMBUS_ARB_RR_EN and 4 continuous contending requests each -> grant order d, i, d, i.
- Slave holds ready = 0 for 3 cycles -> winner ready stays 0 and payload is stable on membus; acceptance happens on the 4th cycle, with no loss or duplicate.
- RESP_TIMEOUT = 8 and the slave never sends rvalid -> owner rvalid with rdata 0 at T+8 and timeout_err = 1 from T+9, staying set until rst. The same test with rvalid exactly at T+8 -> real data returned and timeout_err stays 0.
- rst asserted in WAIT, slave rvalid arrives 2 cycles later -> neither requester sees rvalid; state is IDLE and all outputs are at reset values.
- Write from d (wen = 1, wmask 4'b0011) -> membus carries the same payload, and exactly one d rvalid is returned.
